// File: rtl/ss_mac_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ss_mac_stream_sequencer
// Description : Control and random-source stage for an 8-input 1-bit
//               stochastic MAC. It produces eight per-channel 8-bit LFSR
//               random numbers and a round-robin channel select. It counts
//               the stream length, pulses a clear to the MAC accumulator, and
//               captures the MAC count once the pipeline has drained.
// Revision    : 1.0 - initial release
// ============================================================================
module ss_mac_stream_sequencer #(
  parameter int LEN_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [8:0]       z_in,
  output logic             mac_clr,
  output logic             run,
  output logic [2:0]       sel,
  output logic [7:0]       randnum_0,
  output logic [7:0]       randnum_1,
  output logic [7:0]       randnum_2,
  output logic [7:0]       randnum_3,
  output logic [7:0]       randnum_4,
  output logic [7:0]       randnum_5,
  output logic [7:0]       randnum_6,
  output logic [7:0]       randnum_7,
  output logic             busy,
  output logic             done,
  output logic [8:0]       result
);

  localparam logic [2:0] C_IDLE  = 3'd0;
  localparam logic [2:0] C_CLEAR = 3'd1;
  localparam logic [2:0] C_RUN   = 3'd2;
  localparam logic [2:0] C_DRAIN = 3'd3;
  localparam logic [2:0] C_DONE  = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len_q;
  logic [8:0]       r_result;
  logic             w_last;
  logic [7:0][7:0]  w_rand;

  // The last stream cycle is the one whose index equals len_q-1.
  assign w_last = (r_cnt == (r_len_q - LEN_W'(1)));

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_IDLE:  if (start) w_state_nxt = C_CLEAR;
      C_CLEAR: w_state_nxt = (r_len_q != '0) ? C_RUN : C_DRAIN;
      C_RUN:   if (w_last) w_state_nxt = C_DRAIN;
      C_DRAIN: w_state_nxt = C_DONE;
      C_DONE:  w_state_nxt = C_IDLE;
      default: w_state_nxt = C_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= C_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Length latch and stream-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_len_q <= '0;
    end else if (r_state == C_IDLE && start) begin
      r_cnt   <= '0;
      r_len_q <= len;
    end else if (r_state == C_RUN && !w_last) begin
      r_cnt   <= r_cnt + LEN_W'(1);
    end
  end

  // Capture the MAC count at the end of DRAIN, when the final sum is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_result <= '0;
    else if (r_state == C_DRAIN) r_result <= z_in;
  end

  // One Fibonacci LFSR per channel: seeded in CLEAR, stepped in RUN.
  for (genvar k = 0; k < 8; k++) begin : g_lfsr
    localparam logic [7:0] C_SEED = 8'((37 * k + 1) % 256);
    logic [7:0] r_lfsr;

    // Seed on reset/CLEAR, advance one step per stream cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                     r_lfsr <= C_SEED;
      else if (r_state == C_CLEAR) r_lfsr <= C_SEED;
      else if (r_state == C_RUN)
        r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end

    assign w_rand[k] = r_lfsr;
  end

  assign mac_clr   = (r_state == C_CLEAR);
  assign run       = (r_state == C_RUN);
  assign done      = (r_state == C_DONE);
  assign busy      = (r_state != C_IDLE);
  assign sel       = run ? r_cnt[2:0] : 3'd0;
  assign result    = r_result;

  assign randnum_0 = w_rand[0];
  assign randnum_1 = w_rand[1];
  assign randnum_2 = w_rand[2];
  assign randnum_3 = w_rand[3];
  assign randnum_4 = w_rand[4];
  assign randnum_5 = w_rand[5];
  assign randnum_6 = w_rand[6];
  assign randnum_7 = w_rand[7];

endmodule
`default_nettype wire
